// File: rtl/br_stack.sv
// br_stack: branch-ID stack that allocates one-hot IDs and resolves them by CLEAR or SQUASH.
// The optional protocol checker is enabled by defining BR_STACK_CHECK_EN.
// Ports:
//   clock, reset             - clock; asynchronous active-high reset
//   alloc_en/_ckpt/_target   - allocation request and the data stored with the new ID
//   alloc_b_id               - combinational one-hot grant (zero when nothing is granted)
//   cur_b_mask, full         - live-ID mask and full flag, both registered
//   res_valid/_task/_b_id    - resolve request from the branch FU
//   rem_br_task, rem_b_id    - registered broadcast of an accepted resolve
//   restore_ckpt, redirect_pc- checkpoint and target of a squashed ID
//   err                      - sticky protocol-error flag (always 0 unless the checker is enabled)
package br_stack_pkg;
    typedef enum logic [1:0] {NOTHING = 2'd0, CLEAR = 2'd1, SQUASH = 2'd2} br_task_t;
endpackage

module br_stack
    import br_stack_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int CKPT_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alloc_en,
    input  logic [CKPT_W-1:0] alloc_ckpt,
    input  logic [31:0]       alloc_target,
    output logic [DEPTH-1:0]  alloc_b_id,
    output logic [DEPTH-1:0]  cur_b_mask,
    output logic              full,
    input  logic              res_valid,
    input  br_task_t          res_task,
    input  logic [DEPTH-1:0]  res_b_id,
    output br_task_t          rem_br_task,
    output logic [DEPTH-1:0]  rem_b_id,
    output logic [CKPT_W-1:0] restore_ckpt,
    output logic [31:0]       redirect_pc,
    output logic              err
);
    logic [DEPTH-1:0]  valid, valid_nx, kill, clr_mask, grant;
    logic [DEPTH-1:0]  dep [DEPTH];
    logic [CKPT_W-1:0] ckpt [DEPTH];
    logic [31:0]       tgt [DEPTH];
    logic [CKPT_W-1:0] sel_ckpt;
    logic [31:0]       sel_tgt;
    logic              accept, clr, sq;

    always_comb begin
        accept   = res_valid && (res_task == CLEAR || res_task == SQUASH) && |(res_b_id & valid);
        clr      = accept && res_task == CLEAR;
        sq       = accept && res_task == SQUASH;
        clr_mask = clr ? res_b_id : '0;
        kill     = '0;
        grant    = '0;
        sel_ckpt = '0;
        sel_tgt  = '0;
        // Descending scan so the last hit on an invalid entry is the lowest index.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            // A squash kills the resolved entry plus everything allocated behind it.
            if (sq && (res_b_id[i] || |(dep[i] & res_b_id))) kill[i] = 1'b1;
            if (res_b_id[i]) begin
                sel_ckpt = sel_ckpt | ckpt[i];
                sel_tgt  = sel_tgt | tgt[i];
            end
            if (!valid[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
        if (!alloc_en || full || sq) grant = '0;
        valid_nx = (valid & ~clr_mask & ~kill) | grant;
    end

    assign alloc_b_id = grant;
    assign cur_b_mask = valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid        <= '0;
            full         <= 1'b0;
            rem_br_task  <= NOTHING;
            rem_b_id     <= '0;
            restore_ckpt <= '0;
            redirect_pc  <= '0;
            for (int i = 0; i < DEPTH; i++) dep[i] <= '0;
        end else begin
            valid        <= valid_nx;
            full         <= &valid_nx;
            rem_br_task  <= accept ? res_task : NOTHING;
            rem_b_id     <= accept ? res_b_id : '0;
            restore_ckpt <= sq ? sel_ckpt : '0;
            redirect_pc  <= sq ? sel_tgt : '0;
            // A new entry depends on every live ID except one retiring this same cycle.
            for (int i = 0; i < DEPTH; i++)
                dep[i] <= grant[i] ? (valid & ~clr_mask) : (dep[i] & ~clr_mask);
        end
    end

    // Payload needs no reset: it is only read while its entry is valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++)
            if (grant[i]) begin
                ckpt[i] <= alloc_ckpt;
                tgt[i]  <= alloc_target;
            end
    end

`ifdef BR_STACK_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) err <= 1'b0;
        else if ((res_valid && res_task != NOTHING && (!(|(res_b_id & valid)) || !$onehot(res_b_id)))
                 || (alloc_en && full)) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_br_stack.sv
// tb_br_stack: scoreboard bench for br_stack; expectations are queued at drive time and drained after each edge.
module tb_br_stack;
    import br_stack_pkg::*;
    localparam int DEPTH = 4;
    localparam int F_CUR = 0, F_FULL = 1, F_TASK = 2, F_BID = 3, F_CKPT = 4, F_PC = 5, F_ERR = 6;

    logic             clock = 1'b0, reset = 1'b0;
    logic             alloc_en = 1'b0, res_valid = 1'b0;
    logic [63:0]      alloc_ckpt = '0;
    logic [31:0]      alloc_target = '0, redirect_pc;
    logic [DEPTH-1:0] alloc_b_id, cur_b_mask, res_b_id = '0, rem_b_id;
    logic             full, err;
    br_task_t         res_task = NOTHING, rem_br_task;
    logic [63:0]      restore_ckpt;

    typedef struct {string tag; int f; logic [63:0] v;} exp_t;
    exp_t exp_q[$];
    int n_chk = 0, n_pass = 0;
`ifdef BR_STACK_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    br_stack #(.DEPTH(DEPTH), .CKPT_W(64)) dut (
        .clock(clock), .reset(reset), .alloc_en(alloc_en), .alloc_ckpt(alloc_ckpt),
        .alloc_target(alloc_target), .alloc_b_id(alloc_b_id), .cur_b_mask(cur_b_mask),
        .full(full), .res_valid(res_valid), .res_task(res_task), .res_b_id(res_b_id),
        .rem_br_task(rem_br_task), .rem_b_id(rem_b_id), .restore_ckpt(restore_ckpt),
        .redirect_pc(redirect_pc), .err(err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [63:0] get(input int f);
        case (f)
            F_CUR:   return 64'(cur_b_mask);
            F_FULL:  return 64'(full);
            F_TASK:  return 64'(rem_br_task);
            F_BID:   return 64'(rem_b_id);
            F_CKPT:  return restore_ckpt;
            F_PC:    return 64'(redirect_pc);
            default: return 64'(err);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want_v);
        n_chk++;
        if (got === want_v) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, want_v, $time);
    endtask

    task automatic want(input string tag, input int f, input logic [63:0] v);
        exp_q.push_back('{tag, f, v});
    endtask

    task automatic tick;
        exp_t e;
        @(posedge clock);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, get(e.f), e.v);
        end
    endtask

    task automatic drive(input logic a, input logic [31:0] t, input logic rv, input br_task_t k, input logic [3:0] b);
        @(negedge clock);
        alloc_en     = a;
        alloc_target = t;
        alloc_ckpt   = {32'hC0DE0000, t};
        res_valid    = rv;
        res_task     = k;
        res_b_id     = b;
        #1;
    endtask

    task automatic pulse_reset;
        @(negedge clock);
        alloc_en  = 1'b0;
        res_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk("rst_cur", 64'(cur_b_mask), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        reset = 1'b0;
    endtask

    task automatic alloc_chain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 32'h1000 + 32'(i) * 32'h40, 1'b0, NOTHING, 4'b0);
            chk("grant", 64'(alloc_b_id), 64'(1 << i));
            want("chain_cur", F_CUR, 64'((1 << (i + 1)) - 1));
            want("chain_full", F_FULL, 64'(i == DEPTH - 1));
            want("chain_task", F_TASK, 64'(NOTHING));
            tick();
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("rst_cur", 64'(cur_b_mask), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_task", 64'(rem_br_task), 64'(NOTHING));
        chk("rst_bid", 64'(rem_b_id), 64'd0);
        chk("rst_ckpt", restore_ckpt, 64'd0);
        chk("rst_pc", 64'(redirect_pc), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(negedge clock) reset = 1'b0;

        // Fill the stack, then try once more while full.
        alloc_chain(4);
        drive(1'b1, 32'h2000, 1'b0, NOTHING, 4'b0);
        chk("full_grant", 64'(alloc_b_id), 64'd0);
        want("full_cur", F_CUR, 64'hF);
        want("full_full", F_FULL, 64'd1);
        tick();

        // Allocation while full and CLEAR of 0001 in the same cycle.
        drive(1'b1, 32'h2000, 1'b1, CLEAR, 4'b0001);
        chk("clrfull_grant", 64'(alloc_b_id), 64'd0);
        want("clrfull_task", F_TASK, 64'(CLEAR));
        want("clrfull_bid", F_BID, 64'h1);
        want("clrfull_cur", F_CUR, 64'hE);
        want("clrfull_full", F_FULL, 64'd0);
        tick();
        drive(1'b1, 32'h2000, 1'b0, NOTHING, 4'b0);
        chk("reuse_grant", 64'(alloc_b_id), 64'h1);
        want("reuse_cur", F_CUR, 64'hF);
        want("reuse_full", F_FULL, 64'd1);
        want("reuse_task", F_TASK, 64'(NOTHING));
        tick();

        // CLEAR in the middle of a chain removes only that link.
        pulse_reset();
        alloc_chain(3);
        drive(1'b0, 32'h0, 1'b1, CLEAR, 4'b0010);
        want("clr_task", F_TASK, 64'(CLEAR));
        want("clr_bid", F_BID, 64'h2);
        want("clr_cur", F_CUR, 64'h5);
        tick();
        drive(1'b1, 32'h3000, 1'b0, NOTHING, 4'b0);
        chk("clr_regrant", 64'(alloc_b_id), 64'h2);
        want("clr_regrant_cur", F_CUR, 64'h7);
        tick();
        // Entry 0100 no longer depends on bit 1, so squashing the new 0010 leaves it alive.
        drive(1'b0, 32'h0, 1'b1, SQUASH, 4'b0010);
        want("sq_new_cur", F_CUR, 64'h5);
        want("sq_new_pc", F_PC, 64'h3000);
        want("sq_new_ckpt", F_CKPT, {32'hC0DE0000, 32'h3000});
        tick();
        // Entry 0100 still depends on 0001.
        drive(1'b0, 32'h0, 1'b1, SQUASH, 4'b0001);
        want("sq_root_cur", F_CUR, 64'h0);
        want("sq_root_bid", F_BID, 64'h1);
        tick();

        // SQUASH with a simultaneous allocation request.
        pulse_reset();
        alloc_chain(3);
        drive(1'b1, 32'h4000, 1'b1, SQUASH, 4'b0010);
        chk("sq_alloc_grant", 64'(alloc_b_id), 64'd0);
        want("sq_task", F_TASK, 64'(SQUASH));
        want("sq_bid", F_BID, 64'h2);
        want("sq_pc", F_PC, 64'h1040);
        want("sq_ckpt", F_CKPT, {32'hC0DE0000, 32'h1040});
        want("sq_cur", F_CUR, 64'h1);
        want("sq_full", F_FULL, 64'd0);
        tick();
        drive(1'b1, 32'h5000, 1'b0, NOTHING, 4'b0);
        chk("post_sq_grant", 64'(alloc_b_id), 64'h2);
        want("post_sq_task", F_TASK, 64'(NOTHING));
        want("post_sq_pc", F_PC, 64'd0);
        want("post_sq_cur", F_CUR, 64'h3);
        tick();

        // Reset asserted while a squash broadcast is on the outputs.
        drive(1'b0, 32'h0, 1'b1, SQUASH, 4'b0001);
        want("mid_task", F_TASK, 64'(SQUASH));
        tick();
        res_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("async_task", 64'(rem_br_task), 64'(NOTHING));
        chk("async_bid", 64'(rem_b_id), 64'd0);
        chk("async_pc", 64'(redirect_pc), 64'd0);
        chk("async_ckpt", restore_ckpt, 64'd0);
        chk("async_cur", 64'(cur_b_mask), 64'd0);
        @(negedge clock) reset = 1'b0;
        alloc_chain(1);

        // Ignored resolves: NOTHING on a live ID, then CLEAR of an unallocated ID.
        drive(1'b0, 32'h0, 1'b1, NOTHING, 4'b0001);
        want("nop_task", F_TASK, 64'(NOTHING));
        want("nop_cur", F_CUR, 64'h1);
        want("nop_err", F_ERR, 64'd0);
        tick();
        drive(1'b0, 32'h0, 1'b1, CLEAR, 4'b0100);
        want("bad_task", F_TASK, 64'(NOTHING));
        want("bad_bid", F_BID, 64'd0);
        want("bad_cur", F_CUR, 64'h1);
        want("bad_err", F_ERR, 64'(CHK));
        tick();
        drive(1'b0, 32'h0, 1'b0, NOTHING, 4'b0);
        want("sticky_err", F_ERR, 64'(CHK));
        tick();
        pulse_reset();
        chk("err_cleared", 64'(err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
